// File: rtl/mux2_sel_pkg.sv
// Shared definitions for the mux2 select controller: debounce FSM state encoding
// and the counter width helper.
package mux2_sel_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOWN_FILT = 2'd1,
        DOWN      = 2'd2,
        UP_FILT   = 2'd3
    } state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2_f(input longint unsigned value);
        int unsigned w;
        w = 32'd1;
        for (int i = 1; i < 63; i++) begin
            if ((64'd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux2_sel_ctrl_key_filter.sv
// key_filter: 2-flop synchronizer plus a four-state debounce FSM for an active-low
// push button. press_evt is the unregistered press strobe so the parent can update sel on the same edge.
module key_filter
    import mux2_sel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state,
    output logic press_evt
);

    localparam int unsigned CNT_W = clog2_f(longint'(DEB_CYCLES));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 32'd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_key_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_released_nxt;
    logic             r_key_flag;
    logic             r_key_state;

    assign w_key_sync = r_sync2;

    // Synchronizer flops; they reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // State and stable-time counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter clears on every state change and saturates at CNT_MAX.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_key_sync) begin
                    w_state_nxt = DOWN_FILT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            DOWN_FILT: begin
                if (w_key_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (w_key_sync) begin
                    w_state_nxt = UP_FILT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            UP_FILT: begin
                if (!w_key_sync) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the transition being taken.
    always_comb begin
        w_press        = (r_state == DOWN_FILT) && (w_state_nxt == DOWN);
        w_released_nxt = (w_state_nxt == IDLE) || (w_state_nxt == DOWN_FILT);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_flag  <= 1'b0;
            r_key_state <= 1'b1;
        end else begin
            r_key_flag  <= w_press;
            r_key_state <= w_released_nxt;
        end
    end

    assign key_flag  = r_key_flag;
    assign key_state = r_key_state;
    assign press_evt = w_press;

endmodule

// File: rtl/mux2_sel_ctrl.sv
// mux2_sel_ctrl: debounced push button toggles a registered mux2 select.
// Define SEL_AUTO_EN to add the auto_en port and a periodic auto-toggle counter.
module mux2_sel_ctrl
    import mux2_sel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned AUTO_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
`ifdef SEL_AUTO_EN
    input  logic auto_en,
`endif
    output logic sel,
    output logic key_flag,
    output logic key_state
);

    logic w_press;
    logic w_toggle;
    logic r_sel;

    if ((DEB_CYCLES < 32'd2) || (DEB_CYCLES > 32'd16777216) ||
        (AUTO_CYCLES < 32'd2) || (AUTO_CYCLES > 32'd67108864)) begin : g_param_range_bad
        $error("mux2_sel_ctrl: DEB_CYCLES or AUTO_CYCLES out of range");
    end

    key_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_filter (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_state (key_state),
        .press_evt (w_press)
    );

`ifdef SEL_AUTO_EN
    localparam int unsigned AUTO_W = clog2_f(longint'(AUTO_CYCLES));
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_CYCLES - 32'd1);

    logic [AUTO_W-1:0] r_auto_cnt;
    logic              w_auto_wrap;

    assign w_auto_wrap = auto_en && (r_auto_cnt == AUTO_MAX);
    // A press and a wrap on the same edge merge into one inversion.
    assign w_toggle    = w_press || w_auto_wrap;

    // Auto-toggle period counter; idle or a press restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (!auto_en || w_press || w_auto_wrap) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
        end
    end
`else
    assign w_toggle = w_press;
`endif

    // Select register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= 1'b0;
        end else if (w_toggle) begin
            r_sel <= ~r_sel;
        end else begin
            r_sel <= r_sel;
        end
    end

    assign sel = r_sel;

endmodule

// File: tb/tb_mux2_sel_ctrl.sv
// Bench for mux2_sel_ctrl: directed scenarios plus random key activity, checked
// every cycle against a run-length debounce model.
module tb_mux2_sel_ctrl;

    localparam int DEB  = 4;
    localparam int AUTO = 10;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic sel;
    logic key_flag;
    logic key_state;
`ifdef SEL_AUTO_EN
    logic auto_en;
`endif

    always #5 clk = ~clk;

    mux2_sel_ctrl #(
        .DEB_CYCLES  (DEB),
        .AUTO_CYCLES (AUTO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
`ifdef SEL_AUTO_EN
        .auto_en   (auto_en),
`endif
        .sel       (sel),
        .key_flag  (key_flag),
        .key_state (key_state)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: key seen two samples late; level flips after DEB+1 consecutive opposite samples.
    bit m_s1, m_s2, m_level, m_sel, m_flag;
    int m_run, m_acnt;
    int flag_cnt, edge_k, first_flag;

    task automatic model_edge();
        bit wrap;
        wrap = 1'b0;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_run = 0;
            m_sel = 1'b0; m_flag = 1'b0; m_acnt = 0;
        end else begin
            m_flag = 1'b0;
            if (m_s2 != m_level) m_run++;
            else m_run = 0;
            if (m_run == DEB + 1) begin
                m_level = m_s2;
                m_run   = 0;
                m_flag  = !m_level;
            end
`ifdef SEL_AUTO_EN
            if (!auto_en || m_flag) m_acnt = 0;
            else if (m_acnt == AUTO - 1) begin m_acnt = 0; wrap = 1'b1; end
            else m_acnt++;
`endif
            if (m_flag || wrap) m_sel = !m_sel;
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        edge_k++;
        if (key_flag === 1'b1) begin
            flag_cnt++;
            if (first_flag < 0) first_flag = edge_k;
        end
        check("sel", sel, m_sel);
        check("key_flag", key_flag, m_flag);
        check("key_state", key_state, m_level);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mark();
        flag_cnt = 0; edge_k = 0; first_flag = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        logic sel_before;
        int toggles;
        rst = 1'b1; key_in = 1'b1;
`ifdef SEL_AUTO_EN
        auto_en = 1'b0;
`endif
        mark();
        steps(3);
        check("reset_sel", sel, 1'b0);
        check("reset_flag", key_flag, 1'b0);
        check("reset_state", key_state, 1'b1);
        rst = 1'b0;

        // Idle key: nothing happens.
        mark();
        steps(50);
        check_int("idle_flags", flag_cnt, 0);
        check("idle_sel", sel, 1'b0);
        check("idle_state", key_state, 1'b1);

        // Clean press held: flag on the 7th edge after the fall.
        key_in = 1'b0; mark();
        steps(12);
        check_int("press_latency", first_flag, 7);
        check_int("press_flags", flag_cnt, 1);
        check("press_sel", sel, 1'b1);
        check("press_state", key_state, 1'b0);
        key_in = 1'b1; mark();
        steps(20);
        check_int("release_flags", flag_cnt, 0);
        check("release_sel", sel, 1'b1);

        // Bounce shorter than the stable time.
        mark();
        key_in = 1'b0; steps(2);
        key_in = 1'b1; steps(1);
        key_in = 1'b0; steps(2);
        key_in = 1'b1; steps(20);
        check_int("bounce_flags", flag_cnt, 0);
        check("bounce_sel", sel, 1'b1);
        check("bounce_state", key_state, 1'b1);

        // Two presses from a fresh reset.
        do_reset(); mark();
        key_in = 1'b0; steps(10);
        check("two_sel_1", sel, 1'b1);
        key_in = 1'b1; steps(20);
        key_in = 1'b0; steps(10);
        check("two_sel_2", sel, 1'b0);
        key_in = 1'b1; steps(20);
        check_int("two_flags", flag_cnt, 2);

        // Reset in the middle of a press re-debounces the held key.
        mark();
        key_in = 1'b0; steps(5);
        rst = 1'b1; steps(2);
        check_int("rst_abort_flags", flag_cnt, 0);
        rst = 1'b0; mark();
        steps(12);
        check_int("rst_redebounce_latency", first_flag, 7);
        check("rst_redebounce_sel", sel, 1'b1);
        key_in = 1'b1; steps(20);

        // Random key activity with occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) key_in = ~key_in;
            rst = ($urandom_range(0, 199) == 0);
`ifdef SEL_AUTO_EN
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
`endif
            step();
        end
        rst = 1'b0; key_in = 1'b1;
        steps(20);

`ifdef SEL_AUTO_EN
        // Periodic toggling, then a press landing on the wrap edge.
        auto_en = 1'b0;
        do_reset();
        auto_en = 1'b1;
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            sel_before = sel;
            step();
            if (sel !== sel_before) toggles++;
        end
        check_int("auto_toggles", toggles, 4);
        for (int i = 0; i < 20 && m_acnt != 3; i++) step();
        check_int("auto_align", m_acnt, 3);
        key_in = 1'b0;
        steps(6);
        sel_before = sel;
        step();
        check("coincide_flag", key_flag, 1'b1);
        check("coincide_sel", sel, ~sel_before);
        steps(9);
        sel_before = sel;
        step();
        check("after_coincide_wrap", sel, ~sel_before);
        key_in = 1'b1;
        steps(20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux2_sel_ctrl.md
MUX2_SEL_CTRL -- requirements
Module: mux2_sel_ctrl

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 1000000, debounce stable-time in clk cycles (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter: AUTO_CYCLES, 50000000, auto-toggle period in clk cycles when SEL_AUTO_EN is defined; legal range 2..2^26.
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock or reset.
REQ-004 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port: key_in  input  1  raw push-button, active-low, asynchronous to clk, bouncy.
REQ-007 SHALL have port: sel  output  1  registered select for the downstream mux2 sel input.
REQ-008 SHALL have port: key_flag  output  1  one-cycle pulse per debounced press.
REQ-009 SHALL have port: key_state  output  1  debounced key level; 1 = released, 0 = pressed.
REQ-010 SHALL have port, only when SEL_AUTO_EN is defined: auto_en  input  1  enables periodic sel toggling.

Function
REQ-011 SHALL pass key_in through a 2-flop synchronizer (key_sync) before any other use.
REQ-012 SHALL implement a 4-state FSM: IDLE (released), DOWN_FILT, DOWN (pressed), UP_FILT.
REQ-013 Transitions: IDLE->DOWN_FILT on key_sync=0, cnt<=0; DOWN->UP_FILT on key_sync=1, cnt<=0.
REQ-014 In DOWN_FILT: key_sync=1 -> IDLE, cnt<=0 (bounce rejected); cnt=DEB_CYCLES-1 -> DOWN; otherwise cnt<=cnt+1.
REQ-015 In UP_FILT: key_sync=0 -> DOWN, cnt<=0; cnt=DEB_CYCLES-1 -> IDLE; otherwise cnt<=cnt+1.
REQ-016 On the DOWN_FILT->DOWN transition edge: key_flag SHALL be 1 for exactly one cycle and sel SHALL invert.
REQ-017 Latency: with key_in low and stable from before edge 1, key_flag and the new sel SHALL appear after edge DEB_CYCLES+3.
REQ-018 key_state SHALL be 0 in DOWN and UP_FILT and 1 in IDLE and DOWN_FILT.
REQ-019 Release SHALL NOT generate key_flag and SHALL NOT toggle sel.
REQ-020 cnt SHALL be ceil(log2(DEB_CYCLES)) bits wide and SHALL never wrap; it clears on every state change.

Reset
REQ-021 While rst=1 at a clk edge: state=IDLE, cnt=0, both synchronizer flops=1, sel=0, key_flag=0, key_state=1, auto counter=0.
REQ-022 Reset asserted mid-filter or mid-press SHALL abort the operation with no key_flag pulse; after release, a still-held key SHALL be re-debounced from IDLE.

Configuration
REQ-023 Macro SEL_AUTO_EN: when defined, the auto_en port and an auto counter of ceil(log2(AUTO_CYCLES)) bits SHALL exist.
REQ-024 With SEL_AUTO_EN and auto_en=1: the counter SHALL count 0..AUTO_CYCLES-1; on AUTO_CYCLES-1 it SHALL wrap to 0 and invert sel.
REQ-025 With SEL_AUTO_EN: auto_en=0 SHALL hold the counter at 0. A debounced press SHALL clear the counter. A press coinciding with the wrap SHALL cause exactly one sel inversion.
REQ-026 Without SEL_AUTO_EN: no auto_en port, no auto counter; sel SHALL change only per REQ-016.

Structure
REQ-027 Package mux2_sel_pkg SHALL hold the FSM state encoding constants (IDLE=0, DOWN_FILT=1, DOWN=2, UP_FILT=3) and the log2 width function.
REQ-028 The synchronizer and the debounce FSM SHALL be one sub-module, key_filter (outputs key_flag, key_state); mux2_sel_ctrl SHALL hold the sel register and the auto counter.

Verification
REQ-029 Bench SHALL use DEB_CYCLES=4 and AUTO_CYCLES=10, and SHALL cover the following scenarios:
- Reset then key_in held 1 for 50 cycles -> sel=0, key_flag never 1, key_state=1.
- key_in 1->0 and held -> key_flag high only in cycle 7 after the fall, sel 0->1 the same cycle, key_state=0.
- key_in low 2 cycles, high 1, low 2, high (bounce) -> no key_flag, sel unchanged, FSM back in IDLE.
- Two clean presses separated by a 20-cycle release -> two key_flag pulses, sel 0->1->0, no pulse on either release.
- rst asserted at cycle 5 of a held press, released, key still low -> no flag during reset; flag 7 cycles after rst deasserts.
- SEL_AUTO_EN, auto_en=1, no press -> sel toggles every 10 cycles; press coinciding with the wrap -> single toggle, counter=0.
